// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the 64-bit pipelined ARM core.
// Build option: define BRANCH_DELAY_SLOT_EN to keep the word fetched alongside a taken branch.
module fetch_stage #(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    input  logic              br_taken,
    input  logic              uncond_br,
    input  logic              is_br,
    input  logic [ADDR_W-1:0] br_reg_val,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } state_e;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic KEEP_DELAY_SLOT = 1'b1;
`else
    localparam logic KEEP_DELAY_SLOT = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic [ADDR_W-1:0] if_id_pc4_q, if_id_pc4_d;
    logic              if_id_valid_q, if_id_valid_d;

    logic              redirect_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] off_b_s;
    logic [ADDR_W-1:0] off_bcond_s;

    assign imem_req    = reset;
    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;

    // Resolve the branch sitting in ID; evaluation order keeps X on br_taken/uncond_br out of pc.
    always_comb begin
        off_b_s     = {{(ADDR_W-28){if_id_instr_q[25]}}, if_id_instr_q[25:0], 2'b00};
        off_bcond_s = {{(ADDR_W-21){if_id_instr_q[23]}}, if_id_instr_q[23:5], 2'b00};
        redirect_s  = 1'b0;
        target_s    = br_reg_val;
        if (!stall_i && if_id_valid_q && (is_br || br_taken)) begin
            redirect_s = 1'b1;
        end else begin
            redirect_s = 1'b0;
        end
        if (is_br) begin
            target_s = br_reg_val;
        end else if (uncond_br) begin
            target_s = if_id_pc_q + off_b_s;
        end else begin
            target_s = if_id_pc_q + off_bcond_s;
        end
    end

    // Next PC, fetch state and IF/ID contents.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        if (stall_i) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_FETCH: state_d = imem_ready ? ST_FETCH : ST_WAIT;
                ST_WAIT:  state_d = imem_ready ? ST_FETCH : ST_WAIT;
                default:  state_d = ST_FETCH;
            endcase
            if (imem_ready) begin
                pc_d = pc_q + PC_STEP;
            end else begin
                pc_d = pc_q;
            end
            // The word fetched next to a taken branch is squashed unless it is a delay slot.
            if (imem_ready && !(redirect_s && !KEEP_DELAY_SLOT)) begin
                if_id_instr_d = imem_rdata;
                if_id_pc_d    = pc_q;
                if_id_pc4_d   = pc_q + PC_STEP;
                if_id_valid_d = 1'b1;
            end else begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
            if (redirect_s) begin
                pc_d    = target_s;
                state_d = ST_FETCH;
            end else begin
                state_d = state_d;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= {ADDR_W{1'b0}};
            if_id_pc4_q   <= {ADDR_W{1'b0}};
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 64-bit pipelined ARM core.
- Sits directly upstream of control_unit: drives the instruction word it decodes.
- Consumes its branch outputs (BrTaken, UncondBr, is_BR) to redirect the PC; branches resolve in ID.
- Owns the PC, the instruction-memory request handshake, stall hold and branch flush.

Parameters:
- ADDR_W, 64, PC / address width.
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word; decodes to all-zero controls through the default decode arm.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- stall_i  input  1  hazard-unit stall; holds PC and IF/ID
- imem_req  output  1  fetch request valid
- imem_addr  output  ADDR_W  fetch address (current PC)
- imem_rdata  input  32  instruction word, valid when imem_ready=1
- imem_ready  input  1  memory returns imem_rdata this cycle
- br_taken  input  1  BrTaken from control_unit
- uncond_br  input  1  UncondBr from control_unit
- is_br  input  1  is_BR from control_unit
- br_reg_val  input  ADDR_W  forwarded register value for BR
- if_id_instr  output  32  instruction in ID (feeds control_unit instr)
- if_id_pc  output  ADDR_W  PC of if_id_instr
- if_id_pc4  output  ADDR_W  if_id_pc+4, BL link value
- if_id_valid  output  1  if_id_instr is a real instruction

Behaviour:
- Reset (reset=0 at clk edge) sets:
  - pc=RESET_PC, state=FETCH.
  - if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0.
- While reset=0, imem_req=0. Reset taken mid-WAIT abandons the outstanding fetch.
- Outside reset, imem_req=1 in both states and imem_addr=pc (combinational from the pc register).
- Fetch latency: a word returned with imem_ready=1 at edge N appears on if_id_* after edge N; its branch resolves in cycle N+1.
- States:
  - FETCH: if imem_ready=0, go to WAIT.
  - WAIT: hold pc and re-present the same address; on imem_ready=1, capture the word and return to FETCH.
- Capture:
  - if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_pc4<=pc+4, if_id_valid<=1.
  - pc<=pc+4 unless a redirect occurs.
- No word (imem_ready=0) and no stall: IF/ID loads NOP_INSTR with if_id_valid=0.
- Stall (stall_i=1):
  - pc, IF/ID and state are all held; a returned word is discarded and re-fetched.
  - No redirect is evaluated.
- Redirect condition: stall_i=0 and if_id_valid=1 and (is_br=1 or br_taken=1).
- Redirect target:
  - is_br=1: br_reg_val. br_taken and uncond_br are ignored; is_br has priority.
  - uncond_br=1: if_id_pc + (sext(if_id_instr[25:0])<<2).
  - uncond_br=0: if_id_pc + (sext(if_id_instr[23:5])<<2).
- On redirect:
  - pc<=target and state<=FETCH, regardless of imem_ready or prior state.
  - The word fetched that cycle is handled per the Optional Feature.
- Arithmetic: all PC adds are modulo 2^ADDR_W; pc=all-ones-minus-3 plus 4 wraps to 0.
- Unknowns: br_taken/uncond_br are X-tolerant when if_id_valid=0 or is_br=1; no X may reach pc or the IF/ID registers.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: the word at branch_pc+4 fetched in the redirect cycle is captured normally, valid=1, and executes as a delay slot.
- Undefined: that word is squashed; IF/ID loads NOP_INSTR, valid=0, so one bubble follows every taken branch.
- Redirect target and timing are identical in both builds.

Test Plan:
- Reset held low 2 cycles, then high, with imem_ready=1 and mem[i]=i:
  - imem_addr steps 0,4,8.
  - First if_id_instr=0x0 with valid=0, then words at pc 0,4 with valid=1, if_id_pc4=pc+4.
- B with imm26=3 at pc 8, br_taken=1, uncond_br=1:
  - pc becomes 20 the next cycle.
  - Word at 12 squashed (valid=0), or kept with BRANCH_DELAY_SLOT_EN.
- B.LT with imm19=-2 at pc 16, br_taken=1, uncond_br=0 -> pc becomes 8; with br_taken=0 -> pc becomes 24.
- BR with is_br=1, br_reg_val=0x100, br_taken=X -> pc=0x100, no X on any output.
- stall_i=1 for 3 cycles during a taken branch in ID -> pc and IF/ID frozen, redirect occurs only in the first unstalled cycle.
- imem_ready=0 for 2 cycles at pc 4:
  - imem_addr held at 4, IF/ID bubbles.
  - Reset asserted in 2nd WAIT cycle -> pc=0, state FETCH, valid=0.
